aqp_esp_uart_rx: RTL
====================

Name: aqp_esp_uart_rx

Overview:
Serial receiver for the ESP32 UART link. It is the counterpart of the existing ESP UART transmitter: 8N1 framing, LSB first, a fixed number of clk cycles per bit.
- Oversamples uart_rxd, validates start and stop bits, and pushes each good byte into a small first-word-fall-through (FWFT) FIFO.
- The FIFO is drained by the host-side command/bus logic over a valid/ready handshake.

Parameters:
CLKS_PER_BIT, 8, clk cycles per serial bit; must be even and >= 4.
FIFO_DEPTH_LOG2, 3, log2 of RX FIFO depth (8 entries).
RTS_THRESHOLD, 6, FIFO level at or above which RTS is deasserted (only used with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
uart_rxd  in  1  serial input from ESP; asynchronous to clk; idle high
rx_data  out  8  FIFO head byte; valid while rx_valid=1
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready
rx_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
rx_overflow  out  1  sticky: a good byte was dropped because the FIFO was full
rx_framing_err  out  1  sticky: stop bit sampled low
status_clr  in  1  single-cycle pulse; clears both sticky flags
uart_rts  out  1  active-low request-to-send to ESP

Behaviour:
- Reset values:
  - Synchronizer flops = 1; state = IDLE; FIFO empty.
  - rx_valid=0, rx_level=0, rx_overflow=0, rx_framing_err=0, uart_rts=0, rx_data=don't-care.
  - Reset asserted mid-frame abandons the frame; nothing is pushed.
- Input conditioning: uart_rxd passes through a 2-FF synchronizer; "rxd" below means the synchronized value.
- Bit counter: width $clog2(CLKS_PER_BIT), local to the FSM; it restarts on every state entry. This differs from the transmitter's free-running counter.
- IDLE: when rxd==0, go to START and load the counter for CLKS_PER_BIT/2 cycles.
- START: at expiry sample rxd.
  - 0: go to DATA, bit index = 0, counter = CLKS_PER_BIT.
  - 1: glitch; return to IDLE with no flags set.
- DATA: every CLKS_PER_BIT cycles sample rxd into shift[bit index], LSB first. After bit 7 is sampled, go to STOP with counter = CLKS_PER_BIT.
- STOP: at expiry sample rxd.
  - 1: push the byte, then go to IDLE.
  - 0: set rx_framing_err, do not push, go to BREAK.
- BREAK: stay until rxd==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Sample points fall at mid-bit: CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after the synchronized falling edge.
- FIFO:
  - FWFT, registered pointers; rx_data = mem[rd_ptr].
  - A push in cycle N gives rx_valid=1 and an updated rx_level from cycle N+1.
  - Pop on rx_valid && rx_ready; rd_ptr advances and the next entry appears the following cycle.
- Full FIFO:
  - Push without pop: byte dropped, rx_overflow set.
  - Push with pop in the same cycle: both happen, no overflow, rx_level unchanged.
- Empty FIFO: rx_ready is ignored.
- Pointers are FIFO_DEPTH_LOG2 bits and wrap modulo depth. Full/empty are derived from rx_level.
- Sticky flags: status_clr clears them. A new error event in the same cycle as status_clr wins (the flag stays set).

Optional Feature:
Macro: AQP_ESP_UART_RX_RTS_EN.
- Defined: uart_rts is registered; it goes to 1 (stop) when rx_level >= RTS_THRESHOLD and returns to 0 when rx_level < RTS_THRESHOLD. The change appears one cycle after the level change.
- Undefined: uart_rts is tied to 0 and RTS_THRESHOLD is unused.
- Reception and overflow behaviour are identical in both builds.

Decomposition:
- Shared package aqp_esp_uart_pkg: FSM state enum (IDLE, START, DATA, STOP, BREAK), UART_DATA_BITS=8, and the default CLKS_PER_BIT=8. The existing transmitter may adopt the same constant.
- One sub-module: aqp_sync_fifo (parameterized width/depth, FWFT, level output, push/pop); the receiver FSM stays in the top module.

Test Plan:
- Serialize 0xA5 at 8 clk/bit, then hold rx_ready=0 → one cycle after the stop sample, rx_valid=1, rx_data=0xA5, rx_level=1, both flags 0.
- Low pulse of 3 clk on an idle line → stays in IDLE, rx_level=0, no flags. Then send 0x00 and 0xFF back-to-back → both popped in order.
- Send 0x3C with the stop bit low, holding the line low for 40 clk → rx_framing_err=1, rx_level=0. Then send 0x55 → accepted. Pulse status_clr → flag clears.
- Send 9 bytes 0x01..0x09 with rx_ready=0 → rx_level=8, rx_overflow=1. Pops yield 0x01..0x08 and rx_valid drops after the 8th pop. Also pop on the same cycle as a push while full → no overflow.
- Assert reset at DATA bit 4 of 0x7E → all outputs return to reset values. The next full frame 0x81 is received correctly.
- With AQP_ESP_UART_RX_RTS_EN defined, fill to 6 → uart_rts=1 the next cycle. Pop to 5 → uart_rts=0. With the macro undefined → uart_rts stays 0 throughout.

Source files
------------

// File: rtl/aqp_esp_uart_pkg.sv
// Shared constants and receiver state encoding for the ESP32 UART link (8N1, LSB first).
package aqp_esp_uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/aqp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output and drop indication.
module aqp_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  head_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  push_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO   = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_s, empty_s, pop_ok_s, push_ok_s;

    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
    always_comb begin
        full_s    = (level_q == FULL_LEVEL);
        empty_s   = (level_q == LVL_ZERO);
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
        push_drop = push && full_s && !pop_ok_s;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LVL_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = !empty_s;
    assign level      = level_q;

endmodule

// File: rtl/aqp_esp_uart_rx.sv
// ESP32 UART 8N1 receiver feeding an FWFT RX FIFO, with sticky overflow/framing flags.
// Define AQP_ESP_UART_RX_RTS_EN to drive uart_rts from the FIFO level; otherwise uart_rts is 0.
module aqp_esp_uart_rx
    import aqp_esp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int RTS_THRESHOLD   = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_rxd,
    output logic [UART_DATA_BITS-1:0]   rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [FIFO_DEPTH_LOG2:0]    rx_level,
    output logic                        rx_overflow,
    output logic                        rx_framing_err,
    input  logic                        status_clr,
    output logic                        uart_rts
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
        RTS_THRESHOLD > (1 << FIFO_DEPTH_LOG2)) begin : g_bad_cfg
        $error("aqp_esp_uart_rx: unsupported parameter combination");
    end

    logic [1:0]                sync_q, sync_d;
    uart_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      ovf_q, ovf_d;
    logic                      ferr_q, ferr_d;
    logic                      rxd_s, cnt_zero_s, push_s, ferr_evt_s, fifo_drop_s;

    assign rxd_s      = sync_q[1];
    assign cnt_zero_s = (cnt_q == CNT_ZERO);
    assign sync_d     = {sync_q[0], uart_rxd};

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Frame receiver next state; the counter is reloaded on every state entry and counts down to zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_s     = 1'b0;
        ferr_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_zero_s) begin
                    if (!rxd_s) begin
                        state_d   = ST_DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = IDX_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_zero_s) begin
                    shift_d[bit_idx_q] = rxd_s;
                    cnt_d              = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_idx_d = IDX_ZERO;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_zero_s) begin
                    cnt_d = CNT_ZERO;
                    if (rxd_s) begin
                        push_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_evt_s = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Frame receiver state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= IDX_ZERO;
            shift_q   <= {UART_DATA_BITS{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    aqp_sync_fifo #(
        .WIDTH      (UART_DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_data  (shift_q),
        .pop        (rx_ready),
        .head_data  (rx_data),
        .head_valid (rx_valid),
        .level      (rx_level),
        .push_drop  (fifo_drop_s)
    );

    // A new error event in the same cycle as status_clr keeps the flag set.
    always_comb begin
        ovf_d  = (ovf_q  && !status_clr) || fifo_drop_s;
        ferr_d = (ferr_q && !status_clr) || ferr_evt_s;
    end

    // Sticky status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    assign rx_overflow    = ovf_q;
    assign rx_framing_err = ferr_q;

`ifdef AQP_ESP_UART_RX_RTS_EN
    logic rts_q, rts_d;

    assign rts_d = (rx_level >= LVL_W'(RTS_THRESHOLD));

    // Flow-control output lags the level by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= rts_d;
        end
    end

    assign uart_rts = rts_q;
`else
    assign uart_rts = 1'b0;
`endif

endmodule
